// File: rtl/scalar_reg_bank_sb_if.sv
// rtl/scalar_reg_bank_sb_if.sv - read, issue, writeback and init bus of the multi-warp scalar register bank
interface scalar_reg_bank_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32,
  parameter int PC_WIDTH   = 16
) ();
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int RA_W  = $clog2(NUM_REGS);

  logic                            init_valid;
  logic [WID_W-1:0]                init_warp;
  logic [WID_W-1:0]                rd_warp;
  logic [RA_W-1:0]                 rs1_addr;
  logic [RA_W-1:0]                 rs2_addr;
  logic [DATA_WIDTH-1:0]           rs1_data;
  logic [DATA_WIDTH-1:0]           rs2_data;
  logic                            issue_valid;
  logic [RA_W-1:0]                 issue_rd;
  logic                            hazard;
  logic                            wb_valid;
  logic [WID_W-1:0]                wb_warp;
  logic [RA_W-1:0]                 wb_rd;
  logic [2:0]                      wb_src;
  logic [DATA_WIDTH-1:0]           alu_out;
  logic [DATA_WIDTH-1:0]           lsu_out;
  logic [DATA_WIDTH-1:0]           immediate;
  logic [DATA_WIDTH-1:0]           vector_to_scalar_data;
  logic [PC_WIDTH-1:0]             pc;
  logic                            wb_error;
  logic [NUM_WARPS*DATA_WIDTH-1:0] exec_mask;

  modport slave (
    input  init_valid, init_warp, rd_warp, rs1_addr, rs2_addr, issue_valid, issue_rd,
           wb_valid, wb_warp, wb_rd, wb_src, alu_out, lsu_out, immediate,
           vector_to_scalar_data, pc,
    output rs1_data, rs2_data, hazard, wb_error, exec_mask
  );

  modport master (
    output init_valid, init_warp, rd_warp, rs1_addr, rs2_addr, issue_valid, issue_rd,
           wb_valid, wb_warp, wb_rd, wb_src, alu_out, lsu_out, immediate,
           vector_to_scalar_data, pc,
    input  rs1_data, rs2_data, hazard, wb_error, exec_mask
  );
endinterface

// File: rtl/scalar_reg_bank_sb.sv
// rtl/scalar_reg_bank_sb.sv - multi-warp scalar register file with write bypass and busy scoreboard
module scalar_reg_bank_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32,
  parameter int MASK_REG   = NUM_REGS - 1,
  parameter int PC_WIDTH   = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  scalar_reg_bank_sb_if.slave bus
);
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int RA_W  = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_bank [NUM_WARPS][NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy [NUM_WARPS];
  logic                  r_wb_error;

  logic [PC_WIDTH:0]     w_pc1;
  logic [DATA_WIDTH-1:0] w_wb_val;
  logic                  w_src_ok;
  logic                  w_wb_fire;
  logic                  w_wb_hit_rd;
  logic [NUM_REGS-1:0]   w_busy_rd;
  logic                  w_hazard;
  logic                  w_issue_fire;

  function automatic logic [DATA_WIDTH-1:0] f_rst_val(input int r);
    return (r == 1 || r == MASK_REG) ? '1 : '0;
  endfunction

  assign w_pc1    = {1'b0, bus.pc} + 1'b1;
  assign w_src_ok = (bus.wb_src <= 3'd4);

  always_comb begin
    w_wb_val = '0;
    case (bus.wb_src)
      3'd0:    w_wb_val = bus.alu_out;
      3'd1:    w_wb_val = bus.lsu_out;
      3'd2:    w_wb_val = bus.immediate;
      3'd3:    w_wb_val = DATA_WIDTH'(w_pc1);
      3'd4:    w_wb_val = bus.vector_to_scalar_data;
      default: w_wb_val = '0;
    endcase
  end

  assign w_wb_fire   = bus.wb_valid && (bus.wb_rd != '0) && w_src_ok;
  assign w_wb_hit_rd = w_wb_fire && (bus.wb_warp == bus.rd_warp);

  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (i_reset) begin
      if (bus.rs1_addr != '0)
        bus.rs1_data = (w_wb_hit_rd && bus.wb_rd == bus.rs1_addr) ? w_wb_val
                                                                   : r_bank[bus.rd_warp][bus.rs1_addr];
      if (bus.rs2_addr != '0)
        bus.rs2_data = (w_wb_hit_rd && bus.wb_rd == bus.rs2_addr) ? w_wb_val
                                                                   : r_bank[bus.rd_warp][bus.rs2_addr];
    end
  end

  // A reservation being retired by this cycle's writeback no longer blocks issue.
  always_comb begin
    w_busy_rd = r_busy[bus.rd_warp];
    if (w_wb_hit_rd)
      w_busy_rd[bus.wb_rd] = 1'b0;
    w_busy_rd[0] = 1'b0;
    w_hazard = i_reset && (w_busy_rd[bus.rs1_addr] || w_busy_rd[bus.rs2_addr] ||
                           w_busy_rd[bus.issue_rd]);
  end

  assign bus.hazard  = w_hazard;
  assign w_issue_fire = bus.issue_valid && !w_hazard && (bus.issue_rd != '0);

  // Issue is applied after writeback so a same-register collision leaves the bit set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wb_error <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_busy[w] <= '0;
        for (int r = 0; r < NUM_REGS; r++)
          r_bank[w][r] <= f_rst_val(r);
      end
    end else begin
      r_wb_error <= bus.wb_valid && !w_src_ok;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (bus.init_valid && bus.init_warp == WID_W'(w)) begin
          r_busy[w] <= '0;
          for (int r = 0; r < NUM_REGS; r++)
            r_bank[w][r] <= f_rst_val(r);
        end else begin
          if (w_wb_fire && bus.wb_warp == WID_W'(w)) begin
            r_bank[w][bus.wb_rd] <= w_wb_val;
            r_busy[w][bus.wb_rd] <= 1'b0;
          end
          if (w_issue_fire && bus.rd_warp == WID_W'(w))
            r_busy[w][bus.issue_rd] <= 1'b1;
        end
      end
    end
  end

  assign bus.wb_error = r_wb_error;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_mask
    assign bus.exec_mask[g*DATA_WIDTH +: DATA_WIDTH] = r_bank[g][MASK_REG];
  end
endmodule

// File: tb/tb_scalar_reg_bank_sb.sv
// tb/tb_scalar_reg_bank_sb.sv - directed scoreboard bench for scalar_reg_bank_sb
module tb_scalar_reg_bank_sb;
  localparam logic [31:0]  ALL1  = 32'hFFFF_FFFF;
  localparam logic [127:0] MASK0 = {ALL1, ALL1, ALL1, ALL1};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scalar_reg_bank_sb_if bus ();

  scalar_reg_bank_sb dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic expect_val(input string tag, input logic [127:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic chk(input logic [127:0] obs);
    exp_t e;
    n_total++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid    = 1'b0;
    bus.issue_valid = 1'b0;
    bus.init_valid  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.init_valid = 0; bus.init_warp = 0; bus.rd_warp = 0;
    bus.rs1_addr = 1; bus.rs2_addr = 0; bus.issue_valid = 0; bus.issue_rd = 0;
    bus.wb_valid = 0; bus.wb_warp = 0; bus.wb_rd = 0; bus.wb_src = 0;
    bus.alu_out = 0; bus.lsu_out = 0; bus.immediate = 0;
    bus.vector_to_scalar_data = 0; bus.pc = 0;
    #12;
    expect_val("in_reset_rs1", 0);            chk(bus.rs1_data);
    expect_val("in_reset_hazard", 0);         chk(bus.hazard);
    expect_val("in_reset_exec_mask", MASK0);  chk(bus.exec_mask);
    expect_val("in_reset_wb_error", 0);       chk(bus.wb_error);

    step();
    reset = 1'b1;
    bus.rd_warp = 2; bus.rs1_addr = 1; bus.rs2_addr = 31;
    #1;
    expect_val("rst_r1", ALL1);      chk(bus.rs1_data);
    expect_val("rst_mask", ALL1);    chk(bus.rs2_data);
    expect_val("rst_hazard", 0);     chk(bus.hazard);

    // Immediate writeback with same-cycle bypass.
    step();
    bus.rd_warp = 1; bus.rs1_addr = 5; bus.rs2_addr = 0;
    bus.wb_valid = 1; bus.wb_warp = 1; bus.wb_rd = 5; bus.wb_src = 2; bus.immediate = 32'h1234;
    #1;
    expect_val("bypass_imm", 32'h1234); chk(bus.rs1_data);
    step();
    idle();
    #1;
    expect_val("stored_imm", 32'h1234); chk(bus.rs1_data);
    bus.rd_warp = 0;
    #1;
    expect_val("other_warp_r5", 0);     chk(bus.rs1_data);

    // Reserve r7 in warp 3, then a blocked issue to r9.
    step();
    bus.rd_warp = 3; bus.rs1_addr = 0; bus.rs2_addr = 0;
    bus.issue_valid = 1; bus.issue_rd = 7;
    #1;
    expect_val("issue_no_hazard", 0);   chk(bus.hazard);
    step();
    bus.issue_rd = 9; bus.rs2_addr = 7;
    #1;
    expect_val("hazard_r7", 1);         chk(bus.hazard);
    step();
    idle();
    #1;
    expect_val("hazard_held", 1);       chk(bus.hazard);
    bus.rs2_addr = 9; bus.issue_rd = 0;
    #1;
    expect_val("r9_not_reserved", 0);   chk(bus.hazard);
    bus.rs2_addr = 7;
    bus.wb_valid = 1; bus.wb_warp = 3; bus.wb_rd = 7; bus.wb_src = 0; bus.alu_out = 32'hA5;
    #1;
    expect_val("hazard_drop_wb", 0);    chk(bus.hazard);
    expect_val("bypass_alu", 32'hA5);   chk(bus.rs2_data);
    step();
    idle();
    #1;
    expect_val("stored_alu", 32'hA5);   chk(bus.rs2_data);
    expect_val("hazard_cleared", 0);    chk(bus.hazard);

    // r0 write is dropped, then an invalid source.
    bus.rs1_addr = 0;
    bus.wb_valid = 1; bus.wb_warp = 3; bus.wb_rd = 0; bus.wb_src = 1; bus.lsu_out = 32'hDEAD;
    step();
    idle();
    #1;
    expect_val("r0_zero", 0);           chk(bus.rs1_data);
    expect_val("r0_no_error", 0);       chk(bus.wb_error);
    bus.wb_valid = 1; bus.wb_warp = 3; bus.wb_rd = 7; bus.wb_src = 6; bus.alu_out = 32'h77;
    #1;
    expect_val("bad_src_no_bypass", 32'hA5); chk(bus.rs2_data);
    step();
    idle();
    #1;
    expect_val("bad_src_error", 1);     chk(bus.wb_error);
    expect_val("bad_src_no_write", 32'hA5); chk(bus.rs2_data);
    step();
    expect_val("error_one_cycle", 0);   chk(bus.wb_error);

    // PC+1 carry, vector-to-scalar bypass, mask export.
    bus.wb_valid = 1; bus.wb_warp = 2; bus.wb_rd = 10; bus.wb_src = 3; bus.pc = 16'hFFFF;
    step();
    idle();
    bus.rd_warp = 2; bus.rs1_addr = 10;
    #1;
    expect_val("pc_plus_1", 32'h0001_0000); chk(bus.rs1_data);
    bus.rd_warp = 0; bus.rs2_addr = 12;
    bus.wb_valid = 1; bus.wb_warp = 0; bus.wb_rd = 12; bus.wb_src = 4;
    bus.vector_to_scalar_data = 32'hCAFE_BABE;
    #1;
    expect_val("bypass_v2s", 32'hCAFE_BABE); chk(bus.rs2_data);
    step();
    bus.wb_warp = 1; bus.wb_rd = 31; bus.wb_src = 2; bus.immediate = 32'hF;
    step();
    idle();
    expect_val("exec_mask_w1", {ALL1, ALL1, 32'h0000_000F, ALL1}); chk(bus.exec_mask);

    // Init beats writeback and issue in the same warp; other-warp writeback survives.
    bus.wb_valid = 1; bus.wb_warp = 0; bus.wb_rd = 4; bus.wb_src = 2; bus.immediate = 32'h99;
    step();
    bus.wb_valid = 0;
    bus.rd_warp = 0; bus.issue_valid = 1; bus.issue_rd = 6; bus.rs1_addr = 0; bus.rs2_addr = 0;
    step();
    idle();
    bus.rs1_addr = 4;
    #1;
    expect_val("pre_init_r4", 32'h99);  chk(bus.rs1_data);
    bus.rs1_addr = 0; bus.rs2_addr = 6;
    #1;
    expect_val("pre_init_busy", 1);     chk(bus.hazard);
    bus.rs2_addr = 0;
    bus.init_valid = 1; bus.init_warp = 0;
    bus.wb_valid = 1; bus.wb_warp = 0; bus.wb_rd = 4; bus.wb_src = 2; bus.immediate = 32'h55;
    bus.issue_valid = 1; bus.issue_rd = 8;
    step();
    idle();
    bus.rs1_addr = 4; bus.rs2_addr = 1;
    #1;
    expect_val("init_r4", 0);           chk(bus.rs1_data);
    expect_val("init_r1", ALL1);        chk(bus.rs2_data);
    bus.rs1_addr = 8; bus.rs2_addr = 6;
    #1;
    expect_val("init_busy_clear", 0);   chk(bus.hazard);
    bus.init_valid = 1; bus.init_warp = 0;
    bus.wb_valid = 1; bus.wb_warp = 1; bus.wb_rd = 20; bus.wb_src = 2; bus.immediate = 32'h42;
    step();
    idle();
    bus.rd_warp = 1; bus.rs1_addr = 20;
    #1;
    expect_val("init_other_warp_wb", 32'h42); chk(bus.rs1_data);

    // Asynchronous reset mid-stream drops reservations.
    bus.rd_warp = 2; bus.rs1_addr = 11; bus.rs2_addr = 0;
    bus.issue_valid = 1; bus.issue_rd = 11;
    step();
    idle();
    #1;
    expect_val("busy_before_reset", 1); chk(bus.hazard);
    #2;
    reset = 1'b0;
    #1;
    expect_val("reset_hazard", 0);      chk(bus.hazard);
    expect_val("reset_rs1", 0);         chk(bus.rs1_data);
    expect_val("reset_exec_mask", MASK0); chk(bus.exec_mask);
    step();
    reset = 1'b1;
    #1;
    expect_val("post_reset_hazard", 0); chk(bus.hazard);
    bus.rs1_addr = 10;
    #1;
    expect_val("post_reset_r10", 0);    chk(bus.rs1_data);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/scalar_reg_bank_sb.md
Name: scalar_reg_bank_sb

Overview:
- Multi-warp scalar register file for the lock-in core, replacing the per-warp single-bank scalar file.
- Holds NUM_WARPS independent banks of NUM_REGS registers.
- Provides two asynchronous read ports with same-cycle write bypass, and one writeback port with the established source mux (ALU, LSU, immediate, PC+1, vector-to-scalar).
- Adds a per-register busy scoreboard for issue hazard detection, per-warp execution-mask export, and single-cycle per-warp bank reinitialisation.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- NUM_WARPS, 4, number of register banks; must be ≥1.
- NUM_REGS, 32, registers per bank; power of two, ≥4.
- MASK_REG, NUM_REGS-1, index of the execution-mask register.
- PC_WIDTH, 16, width of the pc input.
- Derived: WID_W = max(1, clog2(NUM_WARPS)) and RA_W = clog2(NUM_REGS).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, asynchronous active-low reset; low asserts.
- init_valid, in, 1, reinitialise one warp bank.
- init_warp, in, WID_W, bank to reinitialise.
- rd_warp, in, WID_W, warp for the read ports, hazard check and issue.
- rs1_addr, in, RA_W, read port 1 index.
- rs2_addr, in, RA_W, read port 2 index.
- rs1_data, out, DATA_WIDTH, read port 1 data.
- rs2_data, out, DATA_WIDTH, read port 2 data.
- issue_valid, in, 1, instruction issuing in rd_warp.
- issue_rd, in, RA_W, destination to reserve.
- hazard, out, 1, rs1/rs2/issue_rd busy in rd_warp.
- wb_valid, in, 1, writeback request.
- wb_warp, in, WID_W, writeback bank.
- wb_rd, in, RA_W, writeback register.
- wb_src, in, 3, source select: 0 ALU_OUT, 1 LSU_OUT, 2 IMMEDIATE, 3 PC_PLUS_1, 4 VECTOR_TO_SCALAR.
- alu_out, lsu_out, immediate, vector_to_scalar_data, in, DATA_WIDTH each, writeback sources.
- pc, in, PC_WIDTH, source for PC_PLUS_1.
- wb_error, out, 1, registered one-cycle pulse on invalid wb_src.
- exec_mask, out, NUM_WARPS*DATA_WIDTH, concatenated MASK_REG of every bank; warp w occupies bits [w*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset values (reset low, asynchronous; applies to every bank):
  - r0 = 0, r1 = all-ones, MASK_REG = all-ones, all other registers = 0.
  - All busy bits = 0; wb_error = 0.
- While reset is low, rs1_data and rs2_data read 0 and hazard = 0. exec_mask reflects the reset values (all-ones per warp).
- Reads are combinational, zero latency:
  - Index 0 always returns 0.
  - Otherwise returns bank[rd_warp][addr].
  - Bypass: if wb_valid, wb_warp == rd_warp, wb_rd == addr, wb_rd != 0 and wb_src is valid, the port returns the muxed writeback value in the same cycle.
- Writeback (rising edge):
  - Fires when wb_valid, wb_rd != 0 and wb_src ≤ 4; writes bank[wb_warp][wb_rd] and clears busy[wb_warp][wb_rd].
  - PC_PLUS_1 value = pc + 1, computed in PC_WIDTH+1 bits, then zero-extended or truncated to DATA_WIDTH.
  - Writes to r0 are dropped silently with no error.
  - wb_src > 4 with wb_valid: no write, busy unchanged, wb_error = 1 for exactly the next cycle.
- Hazard (combinational):
  - Set when any of busy[rd_warp][rs1_addr], busy[rd_warp][rs2_addr], busy[rd_warp][issue_rd] is 1.
  - Busy bits being cleared by a same-cycle writeback to rd_warp are treated as 0.
  - Index 0 is never busy.
- Issue (rising edge): when issue_valid && !hazard && issue_rd != 0, set busy[rd_warp][issue_rd]. When hazard = 1, issue is ignored and the upstream pipeline stalls and retries.
- Simultaneous events:
  - Issue and writeback to the same warp/register in one cycle: the data write occurs and busy ends set (issue wins).
  - init_valid and writeback/issue to the same warp: init wins; the bank returns to reset values and busy bits clear.
  - init_valid to one warp and writeback to another: both take effect.
  - Writebacks to different warps are independent; one write per cycle total.
- init_valid takes effect at the next edge; bank values are visible on the read ports the following cycle.
- Reset asserted mid-operation clears all state immediately; in-flight reservations are lost.

Test Plan:
- Release reset, rd_warp = 2, rs1 = 1, rs2 = MASK_REG -> rs1_data = 0xFFFFFFFF, rs2_data = 0xFFFFFFFF, exec_mask = all-ones, hazard = 0.
- wb_valid, wb_warp = 1, wb_rd = 5, wb_src = IMMEDIATE, immediate = 0x1234, while rd_warp = 1, rs1 = 5 -> rs1_data = 0x1234 in the same cycle (bypass) and the next cycle; warp 0 r5 still reads 0.
- Issue rd = 7 in warp 3 -> next cycle rs2 = 7 gives hazard = 1 and a second issue to rd = 9 is not reserved. Then wb warp 3, r7, ALU_OUT = 0xA5 -> hazard drops in the wb cycle and r7 reads 0xA5.
- wb_rd = 0 with LSU_OUT = 0xDEAD -> r0 reads 0, wb_error = 0. Then wb_src = 6 -> no register changes, wb_error = 1 for one cycle.
- PC_PLUS_1 with pc = 0xFFFF (PC_WIDTH = 16) -> register = 0x00010000. Write MASK_REG of warp 1 = 0x0000000F -> exec_mask slice 1 = 0x0000000F, other slices unchanged.
- Same-cycle init_valid warp 0 + wb warp 0 r4 = 0x55 + wb unrelated: init wins, warp 0 r4 = 0, r1 = all-ones. Then assert reset mid-stream with busy bits set -> all busy = 0 and outputs at reset values immediately.
